imem_boot_ctrl: RTL and testbench

Boot-time loader and fetch controller for the instruction memory. Accepts a byte stream over a valid/ready handshake, assembles 32-bit instruction words and writes them into an owned instruction array. It holds the CPU stalled until the program ends with the halt word or the array fills, then releases the CPU and serves instruction fetches from the same array. It replaces the file-only program load path, so benchmarks can be downloaded at run time.

---
 rtl/imem_boot_pkg.sv | 22 ++
 rtl/imem_array.sv | 47 ++++
 rtl/imem_boot_ctrl.sv | 162 ++++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_pkg.sv
// ============================================================================
// Module      : imem_boot_pkg
// Description : Shared types and constants for the instruction-memory boot
//               loader / fetch controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_boot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } boot_state_t;

    localparam logic [31:0] NOP_WORD          = 32'h0000_0020;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hB422_1820;

endpackage : imem_boot_pkg

`default_nettype wire

// File: rtl/imem_array.sv
// ============================================================================
// Module      : imem_array
// Description : Instruction storage, one synchronous write port and one
//               registered read port. Preloaded with NOP words when
//               IMEM_BOOT_ROM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_array
    import imem_boot_pkg::*;
#(
    parameter int SIZE       = 64,
    parameter int DATA_WIDTH = 32,
    localparam int AW        = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [SIZE];

`ifdef IMEM_BOOT_ROM_EN
    initial begin
        for (int i = 0; i < SIZE; i++) begin
            mem[i] = DATA_WIDTH'(NOP_WORD);
        end
    end
`else
    // Storage powers up undefined; the loader provides the program.
`endif

    // No reset on storage: contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule : imem_array

`default_nettype wire

// File: rtl/imem_boot_ctrl.sv
// ============================================================================
// Module      : imem_boot_ctrl
// Description : Byte-stream program loader and instruction fetch controller.
//               IMEM_BOOT_ROM_EN: preloaded array, controller leaves reset
//               in RUN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_boot_ctrl
    import imem_boot_pkg::*;
#(
    parameter int          SIZE       = 64,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] HALT_WORD  = DEFAULT_HALT_WORD,
    localparam int         AW         = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [31:0]           fetch_addr,
    output logic [DATA_WIDTH-1:0] fetch_inst,
    output logic                  fetch_valid,
    output logic                  cpu_run,
    output logic                  load_done,
    output logic [AW:0]           word_count,
    output logic                  overflow
);

`ifdef IMEM_BOOT_ROM_EN
    localparam boot_state_t RESET_STATE = RUN;
    localparam logic        RESET_DONE  = 1'b1;
    localparam logic [AW:0] RESET_WC    = (AW+1)'(SIZE);
`else
    localparam boot_state_t RESET_STATE = IDLE;
    localparam logic        RESET_DONE  = 1'b0;
    localparam logic [AW:0] RESET_WC    = '0;
`endif

    boot_state_t           state;
    boot_state_t           state_nx;
    logic                  load_clear;

    logic [1:0]            byte_cnt;
    logic [23:0]           asm_q;
    logic [AW-1:0]         wr_ptr;
    logic                  rx_ready_q;
    logic                  fetch_valid_q;
    logic                  fetch_oob_q;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  accept;
    logic                  last_byte;
    logic [31:0]           word;
    logic                  is_halt;
    logic                  ptr_full;
    logic                  unused_addr_bits;

    assign accept    = rx_valid & rx_ready_q & (state == LOAD);
    assign last_byte = accept & (byte_cnt == 2'd3);
    assign word      = {asm_q, rx_data};
    assign is_halt   = (word == HALT_WORD);
    assign ptr_full  = (wr_ptr == AW'(SIZE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        load_clear = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx   = LOAD;
                    load_clear = 1'b1;
                end
            end
            LOAD: begin
                if (last_byte && (is_halt || ptr_full)) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (start) begin
                    state_nx   = LOAD;
                    load_clear = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt      <= '0;
            asm_q         <= '0;
            wr_ptr        <= '0;
            word_count    <= RESET_WC;
            load_done     <= RESET_DONE;
            overflow      <= 1'b0;
            rx_ready_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_oob_q   <= 1'b0;
        end else begin
            rx_ready_q    <= (state_nx == LOAD);
            fetch_valid_q <= (state == RUN);
            fetch_oob_q   <= |fetch_addr[31:AW+2];
            if (load_clear) begin
                byte_cnt   <= '0;
                asm_q      <= '0;
                wr_ptr     <= '0;
                word_count <= '0;
                load_done  <= 1'b0;
                overflow   <= 1'b0;
            end else if (accept) begin
                asm_q    <= {asm_q[15:0], rx_data};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    wr_ptr     <= wr_ptr + 1'b1;
                    word_count <= word_count + 1'b1;
                    if (is_halt) begin
                        load_done <= 1'b1;
                    end else if (ptr_full) begin
                        load_done <= 1'b1;
                        overflow  <= 1'b1;
                    end
                end
            end
        end
    end

    imem_array #(
        .SIZE       (SIZE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imem_array (
        .clk     (clk),
        .wr_en   (last_byte),
        .wr_addr (wr_ptr),
        .wr_data (DATA_WIDTH'(word)),
        .rd_addr (fetch_addr[AW+1:2]),
        .rd_data (rd_data)
    );

    // Byte offset within a word never selects anything.
    assign unused_addr_bits = ^fetch_addr[1:0];

    assign rx_ready    = rx_ready_q;
    assign cpu_run     = (state == RUN);
    assign fetch_valid = fetch_valid_q & (state == RUN);
    assign fetch_inst  = (fetch_valid && !fetch_oob_q) ? rd_data : DATA_WIDTH'(NOP_WORD);

endmodule : imem_boot_ctrl

`default_nettype wire

// File: tb/tb_imem_boot_ctrl.sv
// ============================================================================
// Module      : tb_imem_boot_ctrl
// Description : Randomized self-checking bench for imem_boot_ctrl against a
//               word-level model of the loaded program.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_boot_ctrl;

    localparam int          SIZE = 64;
    localparam int          AW   = 6;
    localparam logic [31:0] HALT = 32'hB422_1820;
    localparam logic [31:0] NOP  = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_inst;
    logic        fetch_valid;
    logic        cpu_run;
    logic        load_done;
    logic [AW:0] word_count;
    logic        overflow;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] mdl_mem [SIZE];
    bit          mdl_known [SIZE];
    int          exp_wc;
    bit          exp_ovf;
    bit          exp_done;
    logic [7:0]  prog [$];

    imem_boot_ctrl #(
        .SIZE       (SIZE),
        .DATA_WIDTH (32),
        .HALT_WORD  (HALT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .fetch_addr  (fetch_addr),
        .fetch_inst  (fetch_inst),
        .fetch_valid (fetch_valid),
        .cpu_run     (cpu_run),
        .load_done   (load_done),
        .word_count  (word_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word-level reference: group bytes big-endian, stop at halt or full array.
    task automatic model_apply();
        exp_wc   = 0;
        exp_ovf  = 1'b0;
        exp_done = 1'b0;
        for (int i = 0; i + 3 < prog.size() && !exp_done; i += 4) begin
            logic [31:0] w;
            w = {prog[i], prog[i+1], prog[i+2], prog[i+3]};
            mdl_mem[exp_wc]   = w;
            mdl_known[exp_wc] = 1'b1;
            exp_wc++;
            if (w == HALT) begin
                exp_done = 1'b1;
            end else if (exp_wc == SIZE) begin
                exp_done = 1'b1;
                exp_ovf  = 1'b1;
            end
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        prog.push_back(w[31:24]);
        prog.push_back(w[23:16]);
        prog.push_back(w[15:8]);
        prog.push_back(w[7:0]);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = w ^ 32'h1;
        return w;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_start);
        int gap;
        int guard;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            step();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        guard    = 0;
        while (!rx_ready && guard < 16) begin
            step();
            guard++;
        end
        if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        start = with_start;
        step();
        start    = 1'b0;
        rx_valid = 1'b0;
    endtask

    // Load prog; start_at marks a byte index that also carries a start pulse.
    task automatic load_prog(input string tag, input bit do_start, input int start_at);
        if (do_start) pulse_start();
        for (int i = 0; i < prog.size(); i++) begin
            send_byte(prog[i], i == start_at);
            if (i == start_at) begin
                check({tag, "_mid_wc"}, 32'(word_count), 32'((i + 1) / 4));
                check({tag, "_mid_ready"}, 32'(rx_ready), 32'd1);
                check({tag, "_mid_run"}, 32'(cpu_run), 32'd0);
            end
        end
        model_apply();
        check({tag, "_cpu_run"}, 32'(cpu_run), 32'd1);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'(exp_wc));
        check({tag, "_load_done"}, 32'(load_done), 32'(exp_done));
        check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic fetch_check(input string tag, input logic [31:0] addr);
        logic [31:0] exp;
        int          idx;
        fetch_addr = addr;
        step();
        idx = int'(addr[AW+1:2]);
        if (addr >= 32'(SIZE * 4)) exp = NOP;
        else if (mdl_known[idx])   exp = mdl_mem[idx];
        else return;
        check({tag, "_valid"}, 32'(fetch_valid), 32'd1);
        check({tag, "_inst"}, fetch_inst, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < SIZE; i++) mdl_known[i] = 1'b0;
        reset      = 1'b0;
        start      = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        fetch_addr = 32'h0;
        repeat (3) step();
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst_fetch_inst", fetch_inst, NOP);
        check("rst_overflow", 32'(overflow), 32'd0);
`ifdef IMEM_BOOT_ROM_EN
        check("rst_cpu_run", 32'(cpu_run), 32'd1);
        check("rst_word_count", 32'(word_count), 32'(SIZE));
        check("rst_load_done", 32'(load_done), 32'd1);
`else
        check("rst_cpu_run", 32'(cpu_run), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
`endif
        reset = 1'b1;
        step();

        // Short program ending in the halt word.
        prog = {};
        push_word(32'h8C01_0000);
        push_word(32'h3402_0004);
        push_word(HALT);
        load_prog("prog3", 1'b1, -1);
        step();
        fetch_check("p3_w0", 32'h0);
        fetch_check("p3_w1", 32'h4);
        fetch_check("p3_w2", 32'h8);

        // Full array without halt.
        prog = {};
        for (int i = 0; i < SIZE; i++) push_word(rand_word());
        load_prog("ovf", 1'b1, -1);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (3) step();
        check("ovf_257_ready", 32'(rx_ready), 32'd0);
        check("ovf_257_wc", 32'(word_count), 32'(SIZE));
        rx_valid = 1'b0;
        repeat (12) fetch_check("ovf_rand", 32'($urandom_range(0, SIZE - 1) * 4));
        fetch_check("oob_100", 32'h100);
        fetch_check("oob_top", 32'hFFFF_FFFC);
        fetch_check("ovf_last", 32'h0FC);

        // Reload from RUN overwrites word 0.
        start = 1'b1;
        step();
        start = 1'b0;
        check("reload_cpu_run", 32'(cpu_run), 32'd0);
        check("reload_fvalid", 32'(fetch_valid), 32'd0);
        check("reload_inst", fetch_inst, NOP);
        check("reload_wc_clr", 32'(word_count), 32'd0);
        check("reload_done_clr", 32'(load_done), 32'd0);
        check("reload_ovf_clr", 32'(overflow), 32'd0);
        prog = {};
        push_word(rand_word());
        push_word(HALT);
        load_prog("reload", 1'b0, -1);
        step();
        check("reload_first_fvalid", 32'(fetch_valid), 32'd1);
        fetch_check("reload_w0", 32'h0);
        fetch_check("reload_w1", 32'h4);
        fetch_check("reload_w2_stale", 32'h8);

        // Reset after six bytes of a load.
        pulse_start();
        begin
            logic [31:0] w0;
            w0 = rand_word();
            send_byte(w0[31:24], 1'b0);
            send_byte(w0[23:16], 1'b0);
            send_byte(w0[15:8], 1'b0);
            send_byte(w0[7:0], 1'b0);
            send_byte(8'($urandom), 1'b0);
            send_byte(8'($urandom), 1'b0);
            check("mid_rst_wc_before", 32'(word_count), 32'd1);
            mdl_mem[0] = w0;
        end
        reset = 1'b0;
        #1;
        check("mid_rst_ready", 32'(rx_ready), 32'd0);
        check("mid_rst_cpu_run", 32'(cpu_run), 32'd0);
        check("mid_rst_wc", 32'(word_count), 32'd0);
        step();
        reset = 1'b1;
        step();
        check("after_rst_done", 32'(load_done), 32'd0);
        prog = {};
        push_word(HALT);
        load_prog("halt_only", 1'b1, -1);
        step();
        fetch_check("rst_w1_old", 32'h4);
        fetch_check("rst_w2_old", 32'h8);
        fetch_check("rst_w0_halt", 32'h0);

        // start coinciding with the 4th byte of a word.
        prog = {};
        push_word(rand_word());
        push_word(rand_word());
        push_word(rand_word());
        push_word(HALT);
        load_prog("start4th", 1'b1, 7);
        step();
        for (int i = 0; i < 5; i++) fetch_check("s4_fetch", 32'(i * 4));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_imem_boot_ctrl

`default_nettype wire
